alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle 16-bit multiplier that sequences one instance of the Hack `alu` through shift-and-add steps, driving its six control bits (`zx nx zy ny f no`) from a small FSM. It gives software-visible multiply without adding a hardware multiplier: only the existing ALU and three 16-bit registers are used. It sits beside the CPU datapath as a request/response peripheral with valid/ready handshakes on both sides.

## Interface
- `EARLY_EXIT`, default 0: 1 = finish as soon as the remaining multiplier bits are all zero; 0 = fixed latency.
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands `a`, `b` valid
- `in_ready`  out  1  block can accept operands
- `a`  in  16  multiplicand, two's complement
- `b`  in  16  multiplier, two's complement
- `out_valid`  out  1  `product`, `zr`, `ng` valid
- `out_ready`  in  1  consumer takes result
- `product`  out  16  low 16 bits of a*b
- `zr`  out  1  1 when `product` == 0
- `ng`  out  1  equals `product[15]`

## Operation
- Registers: `acc`, `mcand`, `mplier` (16 bits each), `cnt` (5 bits), result register (`product`, `zr`, `ng`).
- States: IDLE, ADD, DBL, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: `acc`<=0, `mcand`<=`a`, `mplier`<=`b`, `cnt`<=0, go to ADD.
- ADD: ALU x=`acc`, y=`mcand`. If `mplier[0]`=1, controls 000010 (x+y); else 001100 (x). `acc`<=ALU out. Go to DBL.
- DBL: ALU x=y=`mcand`, controls 000010 (x+x). `mcand`<=ALU out; `mplier`<=`mplier`>>1 (logical); `cnt`<=`cnt`+1.
  - If `cnt`==15, go to DONE.
  - If `EARLY_EXIT`=1 and the shifted `mplier`==0, go to DONE.
  - Otherwise go to ADD.
- On every DONE entry: `product`<=`acc`, `zr`<=(`acc`==0), `ng`<=`acc[15]`.
- DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Arithmetic: all sums wrap modulo 2^16, no overflow flag. Low 16 bits of the product are correct for signed and unsigned operands.
- The ALU is used combinationally, one operation per cycle. Its own `zr`/`ng` outputs are not used; the result flags are computed from `acc`.
- Result register holds its value from one DONE entry to the next, including while in IDLE and during the next operation.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `zr`=1, `ng`=0, `acc`/`mcand`/`mplier`/`cnt`=0.
- `rst` overrides everything. Reset in ADD, DBL or DONE abandons the operation; the block is in IDLE with reset values on the next cycle.
- Latency, accept edge T to `out_valid` high:
  - `EARLY_EXIT`=0: T+32 always.
  - `EARLY_EXIT`=1: T+2·(k+1), where k is the index of the highest set bit of `b`. `b`=0 gives T+2.
- `in_ready` is 1 only in IDLE. It is 0 from the accept edge until the cycle after the output handshake. There is no accept in the same cycle as an output handshake.
- `out_valid` stays high and `product`/`zr`/`ng` stay stable until `out_ready` is sampled high.
- `in_valid` outside IDLE is ignored. Operands are sampled only on the accept edge; `a` and `b` may change afterwards.
- Throughput: one result per 33 cycles minimum with `EARLY_EXIT`=0 and `out_ready` tied high.

## Test plan
- `EARLY_EXIT`=0, `out_ready`=1, a=3, b=5 -> `out_valid` rises 32 cycles after accept; `product`=15, `zr`=0, `ng`=0; `in_ready` high on the following cycle.
- a=-7, b=6 -> `product`=16'hFFD6, `ng`=1, `zr`=0. a=-1, b=-1 -> `product`=1. a=16'h0100, b=16'h0100 -> `product`=0, `zr`=1 (wrap).
- Hold `out_ready`=0 for 10 cycles after `out_valid`, toggling `a`/`b`/`in_valid` -> `out_valid` stays 1, `product` unchanged, `in_ready`=0, no new accept; release -> IDLE the next cycle.
- `EARLY_EXIT`=1: b=0 -> latency 2, `product`=0; b=5 -> latency 6; b=16'h8000 with a=1 -> latency 32, `product`=16'h8000, `ng`=1.
- Assert `rst` for 1 cycle 10 cycles into an operation -> next cycle IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `zr`=1. A new op a=2, b=2 then returns 4.
- 100 random a/b pairs, both `EARLY_EXIT` values, random `out_ready` stalls -> every `product` equals (a*b) mod 2^16; `zr`/`ng` consistent with `product`; latency matches the formula.

Source files
------------

// File: rtl/alu_mul_seq_if.sv
// Request/response bundle for the sequential multiplier: operand handshake in,
// result handshake out.
interface alu_mul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        zr;
    logic        ng;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, zr, ng
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, zr, ng
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16-bit multiplier that reuses one Hack ALU, one operation per
// cycle, sequenced by a four-state FSM.

module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out
);
    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    assign x_z   = zx ? 16'd0 : x;
    assign x_n   = nx ? ~x_z : x_z;
    assign y_z   = zy ? 16'd0 : y;
    assign y_n   = ny ? ~y_z : y_z;
    assign f_out = f ? (x_n + y_n) : (x_n & y_n);
    assign out   = no ? ~f_out : f_out;
endmodule

module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    alu_mul_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} state_t;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam alu_ctrl_t CTRL_SUM   = alu_ctrl_t'(6'b000010);
    localparam alu_ctrl_t CTRL_PASSX = alu_ctrl_t'(6'b001100);

    state_t      state, state_next;
    logic [15:0] acc, mcand, mplier;
    logic [4:0]  cnt;
    logic [15:0] product;
    logic        zr, ng;

    logic [15:0] mplier_shr;
    logic [15:0] alu_x, alu_y, alu_out;
    alu_ctrl_t   ctrl;
    logic        in_ready, out_valid;

    assign mplier_shr = mplier >> 1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = ADD;
            ADD:     state_next = DBL;
            DBL: begin
                if (cnt == 5'd15 || (EARLY_EXIT && mplier_shr == 16'd0))
                    state_next = DONE;
                else
                    state_next = ADD;
            end
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ctrl      = CTRL_PASSX;
        alu_x     = acc;
        alu_y     = mcand;
        case (state)
            IDLE: in_ready = 1'b1;
            ADD:  ctrl = mplier[0] ? CTRL_SUM : CTRL_PASSX;
            DBL: begin
                alu_x = mcand;
                ctrl  = CTRL_SUM;
            end
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // The ALU's own zero/negative flags are not needed; result flags come from acc.
    alu u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (ctrl.zx),
        .nx  (ctrl.nx),
        .zy  (ctrl.zy),
        .ny  (ctrl.ny),
        .f   (ctrl.f),
        .no  (ctrl.no),
        .out (alu_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= 16'd0;
            mcand   <= 16'd0;
            mplier  <= 16'd0;
            cnt     <= 5'd0;
            product <= 16'd0;
            zr      <= 1'b1;
            ng      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc    <= 16'd0;
                        mcand  <= bus.a;
                        mplier <= bus.b;
                        cnt    <= 5'd0;
                    end
                end
                ADD: acc <= alu_out;
                DBL: begin
                    mcand  <= alu_out;
                    mplier <= mplier_shr;
                    cnt    <= cnt + 5'd1;
                    // acc already holds the final sum when DONE is entered from here
                    if (state_next == DONE) begin
                        product <= acc;
                        zr      <= (acc == 16'd0);
                        ng      <= acc[15];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.product   = product;
    assign bus.zr        = zr;
    assign bus.ng        = ng;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: fixed-latency and early-exit instances,
// scoreboard of expected products and latencies, output back-pressure and reset abort.
module tb_alu_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;

    logic        in_ready, out_valid, zr, ng;
    logic [15:0] product;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] p;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_mul_seq_if if0 ();
    alu_mul_seq_if if1 ();

    assign if0.a = op_a;
    assign if0.b = op_b;
    assign if0.in_valid  = in_valid && !sel;
    assign if0.out_ready = out_ready && !sel;
    assign if1.a = op_a;
    assign if1.b = op_b;
    assign if1.in_valid  = in_valid && sel;
    assign if1.out_ready = out_ready && sel;

    assign in_ready  = sel ? if1.in_ready  : if0.in_ready;
    assign out_valid = sel ? if1.out_valid : if0.out_valid;
    assign product   = sel ? if1.product   : if0.product;
    assign zr        = sel ? if1.zr        : if0.zr;
    assign ng        = sel ? if1.ng        : if0.ng;

    alu_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    alu_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_latency(input bit early, input logic [15:0] y);
        int k = -1;
        if (!early) return 32;
        for (int i = 0; i < 16; i++) if (y[i]) k = i;
        return (k < 0) ? 2 : 2 * (k + 1);
    endfunction

    task automatic do_op(input bit s, input logic [15:0] x, input logic [15:0] y, input int stall);
        exp_t        e;
        int          n;
        logic [15:0] held;
        sel = s;
        #0;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("accept_ready", in_ready, 1);
        e.p   = x * y;
        e.lat = exp_latency(s, y);
        sb.push_back(e);
        op_a = x;
        op_b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        held = product;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_ready", in_ready, 0);
            check("stall_hold", product, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        e = sb.pop_front();
        check("latency", n, e.lat);
        check("out_valid", out_valid, 1);
        check("product", product, e.p);
        check("zr", zr, (e.p == 16'd0));
        check("ng", ng, e.p[15]);
        tick();
        out_ready = 1'b0;
        check("idle_ready", in_ready, 1);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #0;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_product", product, 0);
            check("rst_zr", zr, 1);
            check("rst_ng", ng, 0);
        end

        // Fixed latency: directed values including sign and wrap cases
        do_op(1'b0, 16'd3, 16'd5, 0);
        do_op(1'b0, -16'sd7, 16'd6, 0);
        do_op(1'b0, 16'hFFFF, 16'hFFFF, 0);
        do_op(1'b0, 16'h0100, 16'h0100, 0);
        do_op(1'b0, 16'd1234, 16'd77, 10);

        // Early exit: latency tracks highest set bit of b
        do_op(1'b1, 16'd9, 16'd0, 0);
        do_op(1'b1, 16'd3, 16'd5, 0);
        do_op(1'b1, 16'd1, 16'h8000, 0);
        do_op(1'b1, 16'hABCD, 16'h0001, 3);

        // Abort an operation with a one-cycle reset
        sel = 1'b0;
        op_a = 16'h1234;
        op_b = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_product", product, 0);
        check("abort_zr", zr, 1);
        do_op(1'b0, 16'd2, 16'd2, 0);

        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            do_op(1'(i % 2), ra, rb, $urandom_range(0, 3));
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
